// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES constants, round primitives and FSM encoding.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_state_t;

  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_sbox[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte k of the block sits at [127-8k -: 8], row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic int steps_of(input int cols);
    return 4 / cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_expand                                                       |
// | On-the-fly round-key generator; round_key is the current round key.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [KEY_BITS-1:0] key,
  input  logic                advance,
  output logic [127:0]        round_key
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expand: KEY_BITS must be 128 or 256");
  end

  // Window holds the next KEY_BITS/32 key words, current round key first.
  logic [KEY_BITS-1:0] r_win;
  logic [3:0]          r_rcon_idx;
  logic                r_odd;

  logic [127:0]        w_old;
  logic [31:0]         w_last;
  logic                w_rot;
  logic [31:0]         w_f;
  logic [127:0]        w_new;
  logic [KEY_BITS-1:0] w_win_next;

  assign w_old  = r_win[KEY_BITS-1 -: 128];
  assign w_last = r_win[31:0];
  // AES-256 alternates full and SubWord-only steps between half-windows.
  assign w_rot  = (KEY_BITS == 128) || !r_odd;
  assign w_f    = w_rot ? (sub_word({w_last[23:0], w_last[31:24]}) ^ {rcon(r_rcon_idx), 24'h0})
                        : sub_word(w_last);

  assign w_new[127:96] = w_old[127:96] ^ w_f;
  assign w_new[95:64]  = w_old[95:64]  ^ w_new[127:96];
  assign w_new[63:32]  = w_old[63:32]  ^ w_new[95:64];
  assign w_new[31:0]   = w_old[31:0]   ^ w_new[63:32];

  if (KEY_BITS == 128) begin : g_win128
    assign w_win_next = w_new;
  end else begin : g_win256
    assign w_win_next = {r_win[127:0], w_new};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_win      <= '0;
      r_rcon_idx <= 4'd0;
      r_odd      <= 1'b0;
    end else if (load) begin
      r_win      <= key;
      r_rcon_idx <= 4'd0;
      r_odd      <= 1'b0;
    end else if (advance) begin
      r_win <= w_win_next;
      r_odd <= ~r_odd;
      if (w_rot) begin
        r_rcon_idx <= r_rcon_idx + 4'd1;
      end
    end
  end

  assign round_key = w_old;

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_iter_core                                                        |
// | Iterative AES encryptor, COLS columns per cycle, valid/ready I/O.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int COLS     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  localparam int c_nr    = nr_of(KEY_BITS);
  localparam int c_steps = steps_of(COLS);

  if ((KEY_BITS != 128 && KEY_BITS != 256) || (COLS != 1 && COLS != 2 && COLS != 4))
  begin : g_bad_params
    $error("aes_iter_core: KEY_BITS must be 128/256 and COLS 1/2/4");
  end

  aes_state_t   r_fsm;
  aes_state_t   w_fsm_next;
  logic [127:0] r_work;
  logic [127:0] r_shadow;
  logic [127:0] r_data_out;
  logic [3:0]   r_round;
  logic [1:0]   r_step;

  logic         w_accept;
  logic         w_last_step;
  logic         w_last_round;
  logic         w_key_advance;
  logic [127:0] w_round_key;
  logic [127:0] w_shifted;
  logic [127:0] w_shadow_next;
  logic [6:0]   w_col_base [COLS];
  logic [31:0]  w_col_out  [COLS];

  assign w_accept      = in_valid & in_ready;
  assign w_last_step   = (r_step == 2'(c_steps - 1));
  assign w_last_round  = (r_round == 4'(c_nr));
  assign w_key_advance = (r_fsm == LOAD) || (r_fsm == ROUND && w_last_step && !w_last_round);

  aes_key_expand #(
    .KEY_BITS (KEY_BITS)
  ) u_key_expand (
    .clock     (clock),
    .reset     (reset),
    .load      (w_accept),
    .key       (key_in),
    .advance   (w_key_advance),
    .round_key (w_round_key)
  );

  // SubBytes commutes with ShiftRows, so only the selected columns need S-boxes.
  assign w_shifted = shift_rows(r_work);

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [1:0]  w_idx;
    logic [31:0] w_sub;
    assign w_idx         = 2'(r_step * COLS + j);
    assign w_col_base[j] = 7'd127 - {w_idx, 5'd0};
    assign w_sub         = sub_word(w_shifted[w_col_base[j] -: 32]);
    assign w_col_out[j]  = (w_last_round ? w_sub : mix_col(w_sub))
                         ^ w_round_key[w_col_base[j] -: 32];
  end

  always_comb begin
    w_shadow_next = r_shadow;
    for (int j = 0; j < COLS; j++) begin
      w_shadow_next[w_col_base[j] -: 32] = w_col_out[j];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        w_fsm_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (w_last_step && w_last_round) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_fsm_next = in_valid ? LOAD : IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_work     <= '0;
      r_shadow   <= '0;
      r_data_out <= '0;
      r_round    <= 4'd0;
      r_step     <= 2'd0;
    end else if (w_accept) begin
      r_work  <= data_in;
      r_round <= 4'd0;
      r_step  <= 2'd0;
    end else if (r_fsm == LOAD) begin
      r_work  <= r_work ^ w_round_key;
      r_round <= 4'd1;
      r_step  <= 2'd0;
    end else if (r_fsm == ROUND) begin
      r_shadow <= w_shadow_next;
      if (w_last_step) begin
        r_work  <= w_shadow_next;
        r_step  <= 2'd0;
        r_round <= r_round + 4'd1;
        if (w_last_round) r_data_out <= w_shadow_next;
      end else begin
        r_step <= r_step + 2'd1;
      end
    end
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_iter_core                                                     |
// | Scoreboard bench for three core configurations sharing one clock.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_aes_iter_core;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] data_in   [3];
  logic [127:0] data_out  [3];
  logic [255:0] key_in    [3];

  int           cyc   = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] exp_q [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  aes_iter_core #(.KEY_BITS(128), .COLS(1)) u_dut_k128_c1 (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .key_in(key_in[0][255:128]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0]));

  aes_iter_core #(.KEY_BITS(128), .COLS(4)) u_dut_k128_c4 (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .key_in(key_in[1][255:128]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1]));

  aes_iter_core #(.KEY_BITS(256), .COLS(2)) u_dut_k256_c2 (
    .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in[2]), .key_in(key_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2]));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, req);
    end
  endtask

  // Offer one block; returns the cycle number of the accept cycle.
  task automatic send(input int d, input logic [127:0] pt, input logic [255:0] key,
                      input logic [127:0] ct, output int acc);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    data_in[d]  = pt;
    key_in[d]   = key;
    #1;
    while (!in_ready[d] && n < 300) begin
      @(negedge clock); #1;
      n++;
    end
    if (n >= 300) check_val("accept_timeout", {127'b0, in_ready[d]}, 128'd1);
    acc = cyc;
    exp_q.push_back(ct);
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input int acc, input int lat, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while (!out_valid[d] && n < 300);
    check_val(tag, 128'(cyc - acc), 128'(lat));
  endtask

  always @(negedge clock) begin : mon
    logic [127:0] e;
    #2;
    for (int d = 0; d < 3; d++) begin
      if (reset && out_valid[d] && out_ready[d]) begin
        if (exp_q.size() == 0) begin
          check_val($sformatf("spurious_out_dut%0d", d), {127'b0, out_valid[d]}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check_val($sformatf("ct_dut%0d", d), data_out[d], e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    logic ok;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      data_in[d]   = '0;
      key_in[d]    = '0;
    end
    repeat (3) @(negedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("rst_in_ready%0d", d),  {127'b0, in_ready[d]},  128'd1);
      check_val($sformatf("rst_out_valid%0d", d), {127'b0, out_valid[d]}, 128'd0);
      check_val($sformatf("rst_busy%0d", d),      {127'b0, busy[d]},      128'd0);
      check_val($sformatf("rst_data_out%0d", d),  data_out[d],            128'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    // FIPS-197 C.1 on the one-column core, then output hold after handshake
    out_ready[0] = 1'b1;
    send(0, PT1, {K1, 128'h0}, CT1, acc);
    wait_out(0, acc, 42, "lat_k128_c1");
    @(negedge clock); #1;
    check_val("ov_fall_after_hs", {127'b0, out_valid[0]}, 128'd0);
    check_val("dout_hold_after_hs", data_out[0], CT1);

    // FIPS-197 appendix B on the four-column core
    out_ready[1] = 1'b1;
    @(negedge clock);
    send(1, PT2, {K2, 128'h0}, CT2, acc);
    wait_out(1, acc, 12, "lat_k128_c4");

    // FIPS-197 C.3 on the AES-256 two-column core
    out_ready[2] = 1'b1;
    @(negedge clock);
    send(2, PT1, K3, CT3, acc);
    wait_out(2, acc, 30, "lat_k256_c2");

    // Backpressure: hold the result, ignore new offers, then back-to-back accept
    @(negedge clock);
    out_ready[0] = 1'b0;
    send(0, PT1, {K1, 128'h0}, CT1, acc);
    wait_out(0, acc, 42, "lat_bp_first");
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = 1'b1;
      data_in[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in[0]   = {8{$urandom()}};
      @(negedge clock); #1;
      ok &= (data_out[0] == CT1) && out_valid[0] && !in_ready[0];
    end
    check_val("bp_hold_stable", {127'b0, ok}, 128'd1);
    check_val("bp_nothing_popped", 128'(exp_q.size()), 128'd1);
    out_ready[0] = 1'b1;
    send(0, PT2, {K2, 128'h0}, CT2, acc);
    @(negedge clock); #1;
    check_val("b2b_busy", {127'b0, busy[0]}, 128'd1);
    wait_out(0, acc, 42, "lat_b2b_second");

    // Offer with a different key while the first block is in flight
    @(negedge clock);
    send(0, PT1, {K1, 128'h0}, CT1, acc);
    repeat (10) @(negedge clock);
    in_valid[0] = 1'b1;
    data_in[0]  = PT2;
    key_in[0]   = {K2, 128'h0};
    @(negedge clock);
    in_valid[0] = 1'b0;
    wait_out(0, acc, 42, "lat_mid_pulse");

    // Reset during round 5 aborts with no result emitted
    @(negedge clock);
    send(0, PT2, {K2, 128'h0}, CT2, acc);
    while (cyc < acc + 19) @(negedge clock);
    #1;
    check_val("pre_rst_busy", {127'b0, busy[0]}, 128'd1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_out_valid", {127'b0, out_valid[0]}, 128'd0);
    check_val("mid_rst_data_out", data_out[0], 128'd0);
    check_val("mid_rst_busy", {127'b0, busy[0]}, 128'd0);
    check_val("mid_rst_in_ready", {127'b0, in_ready[0]}, 128'd1);
    void'(exp_q.pop_back());
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send(0, PT1, {K1, 128'h0}, CT1, acc);
    wait_out(0, acc, 42, "lat_after_rst");

    repeat (3) @(negedge clock);
    #3;
    check_val("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
